// File: rtl/sm_addsub_pipe_if.sv
// Stream bundle for the sign-magnitude add/sub pipeline: operand side, result
// side and the accumulator clear strobe.
interface sm_addsub_pipe_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         acc_mode;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, sum, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, sum, ovf, zero
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with saturation, -0 normalisation
// and an optional serialised accumulator that substitutes for operand A.
module sm_addsub_pipe #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset,
  sm_addsub_pipe_if.slave bus
);
  localparam int M = N - 1;

  // Handshake: a beat moves when valid && ready on the same rising edge; valid
  // never depends on ready, and the producer holds its payload until it moves.

  logic [N-1:0] acc;
  logic         s1_valid;
  logic         s1_acc;
  logic         s1_sign;
  logic         s1_sub;
  logic [M-1:0] s1_max;
  logic [M-1:0] s1_min;
  logic         out_valid_q;
  logic         s2_acc;
  logic [N-1:0] sum_q;
  logic         ovf_q;
  logic         zero_q;

  logic [N-1:0] a_eff;
  logic [M-1:0] mag_a;
  logic [M-1:0] mag_b;
  logic         sign_a;
  logic         sign_b;
  logic         a_ge;
  logic         s2_open;
  logic         s1_adv;
  logic         acc_busy;
  logic         take;
  logic [N-1:0] wide;
  logic         res_ovf;
  logic [M-1:0] res_mag;
  logic         res_zero;
  logic [N-1:0] res_word;

  always_comb begin
    a_eff  = bus.acc_mode ? acc : bus.a;
    mag_a  = a_eff[M-1:0];
    mag_b  = bus.b[M-1:0];
    // A zero magnitude carries sign 0 regardless of the sign bit (kills -0).
    sign_a = a_eff[N-1] & (mag_a != '0);
    sign_b = (bus.b[N-1] ^ bus.op) & (mag_b != '0);
    a_ge   = (mag_a >= mag_b);
  end

  always_comb begin
    s2_open  = !out_valid_q || bus.out_ready;
    s1_adv   = s1_valid && s2_open;
    acc_busy = (s1_valid && s1_acc) || (out_valid_q && s2_acc);
    take     = bus.in_valid && bus.in_ready;
  end

  assign bus.in_ready = !reset && !acc_busy && (!s1_valid || s1_adv);

  always_comb begin
    if (s1_sub) wide = {1'b0, s1_max} - {1'b0, s1_min};
    else        wide = {1'b0, s1_max} + {1'b0, s1_min};
    res_ovf  = !s1_sub && wide[M];
    res_mag  = res_ovf ? '1 : wide[M-1:0];
    res_zero = (res_mag == '0);
    res_word = {s1_sign & !res_zero, res_mag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_acc      <= 1'b0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_max      <= '0;
      s1_min      <= '0;
      out_valid_q <= 1'b0;
      s2_acc      <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      acc         <= '0;
    end else begin
      if (take) begin
        s1_valid <= 1'b1;
        s1_acc   <= bus.acc_mode;
        s1_sub   <= (sign_a != sign_b);
        // With equal signs sign_a == sign_b, so this also covers the add case.
        s1_sign  <= a_ge ? sign_a : sign_b;
        s1_max   <= a_ge ? mag_a : mag_b;
        s1_min   <= a_ge ? mag_b : mag_a;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid_q <= 1'b1;
        s2_acc      <= s1_acc;
        sum_q       <= res_word;
        ovf_q       <= res_ovf;
        zero_q      <= res_zero;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (bus.acc_clr)              acc <= '0;
      else if (s1_adv && s1_acc)    acc <= res_word;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
